// File: rtl/spi_memory_slave_burst.sv
// SPI mode-0 memory slave: opcode, multi-byte address, optional dummy cycles and
// auto-incrementing burst read/write, all sampled into the main_clock domain.
module spi_memory_slave_burst #(
    parameter int          ADDR_BYTES    = 2,
    parameter int          DUMMY_CYCLES  = 8,
    parameter logic [7:0]  CMD_WRITE     = 8'h02,
    parameter logic [7:0]  CMD_READ      = 8'h03,
    parameter logic [7:0]  CMD_FAST_READ = 8'h0B,
    localparam int         AW            = 8 * ADDR_BYTES
) (
    input  logic          main_clock,
    input  logic          rst_n,
    input  logic          sck,
    input  logic          cs,
    input  logic          si,
    output logic          so,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    output logic [7:0]    write_data,
    output logic          write_data_valid,
    input  logic [7:0]    read_data,
    output logic          read_data_request,
    output logic          read_data_captured,
    output logic          cmd_error
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_READ   = 3'd4;
    localparam logic [2:0] ST_WRITE  = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;
    localparam int         CW        = 16;

    logic          sck_s1, sck_s2, sck_s3;
    logic          cs_s1, cs_s2, cs_s3;
    logic          si_s1, si_s2;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-2:0] in_sr;
    logic [7:0]    out_sr;
    logic [7:0]    cmd;
    logic          rd_inc, wr_inc;

    logic          sck_rise, sck_fall, cs_fall;
    logic [AW-1:0] shift_next;

    assign sck_rise   = sck_s2 & ~sck_s3;
    assign sck_fall   = ~sck_s2 & sck_s3;
    assign cs_fall    = cs_s3 & ~cs_s2;
    assign shift_next = {in_sr, si_s2};

    // NOTE: every register here is updated with <= so all branches see the pre-edge values.
    always_ff @(posedge main_clock) begin
        if (!rst_n) begin
            {sck_s1, sck_s2, sck_s3} <= '0;
            {cs_s1, cs_s2, cs_s3}    <= '0;
            {si_s1, si_s2}           <= '0;
            state              <= ST_IDLE;
            cnt                <= '0;
            in_sr              <= '0;
            out_sr             <= '0;
            cmd                <= '0;
            rd_inc             <= 1'b0;
            wr_inc             <= 1'b0;
            so                 <= 1'b0;
            addr               <= '0;
            addr_valid         <= 1'b0;
            write_data         <= '0;
            write_data_valid   <= 1'b0;
            read_data_request  <= 1'b0;
            read_data_captured <= 1'b0;
            cmd_error          <= 1'b0;
        end else begin
            {sck_s3, sck_s2, sck_s1} <= {sck_s2, sck_s1, sck};
            {cs_s3, cs_s2, cs_s1}    <= {cs_s2, cs_s1, cs};
            {si_s2, si_s1}           <= {si_s1, si};

            addr_valid         <= 1'b0;
            write_data_valid   <= 1'b0;
            read_data_request  <= 1'b0;
            read_data_captured <= 1'b0;
            cmd_error          <= 1'b0;

            // Deasserted chip select beats any sck edge seen in the same cycle.
            if (cs_s2) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                so     <= 1'b0;
                rd_inc <= 1'b0;
                wr_inc <= 1'b0;
            end else begin
                if (rd_inc) begin
                    addr              <= addr + 1'b1;
                    addr_valid        <= 1'b1;
                    read_data_request <= 1'b1;
                    rd_inc            <= 1'b0;
                end
                if (wr_inc) begin
                    addr   <= addr + 1'b1;
                    wr_inc <= 1'b0;
                end

                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (cs_fall) state <= ST_CMD;
                    end
                    ST_CMD: if (sck_rise) begin
                        in_sr <= shift_next[AW-2:0];
                        if (cnt == CW'(7)) begin
                            cnt <= '0;
                            cmd <= shift_next[7:0];
                            if (shift_next[7:0] == CMD_WRITE || shift_next[7:0] == CMD_READ ||
                                shift_next[7:0] == CMD_FAST_READ) begin
                                state <= ST_ADDR;
                            end else begin
                                state     <= ST_IGNORE;
                                cmd_error <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_ADDR: if (sck_rise) begin
                        in_sr <= shift_next[AW-2:0];
                        if (cnt == CW'(AW - 1)) begin
                            cnt        <= '0;
                            addr       <= shift_next;
                            addr_valid <= 1'b1;
                            if (cmd == CMD_WRITE) begin
                                state <= ST_WRITE;
                            end else begin
                                read_data_request <= 1'b1;
                                state <= (cmd == CMD_FAST_READ && DUMMY_CYCLES > 0) ? ST_DUMMY
                                                                                    : ST_READ;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DUMMY: if (sck_rise) begin
                        if (cnt == CW'(DUMMY_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= ST_READ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_READ: begin
                        // The fall that opens a byte loads the shifter; later falls shift it out.
                        if (sck_fall) begin
                            if (cnt == '0) begin
                                so                 <= read_data[7];
                                out_sr             <= {read_data[6:0], 1'b0};
                                read_data_captured <= 1'b1;
                                rd_inc             <= 1'b1;
                            end else begin
                                so     <= out_sr[7];
                                out_sr <= {out_sr[6:0], 1'b0};
                            end
                        end
                        if (sck_rise) cnt <= (cnt == CW'(7)) ? '0 : cnt + 1'b1;
                    end
                    ST_WRITE: if (sck_rise) begin
                        in_sr <= shift_next[AW-2:0];
                        if (cnt == CW'(7)) begin
                            cnt              <= '0;
                            write_data       <= shift_next[7:0];
                            write_data_valid <= 1'b1;
                            wr_inc           <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_memory_slave_burst.sv
// Bench for spi_memory_slave_burst: bit-banged SPI master plus queue-based scoreboard
// for addr_valid / write_data_valid events and read_data responses.
module tb_spi_memory_slave_burst;
    localparam int AW   = 16;
    localparam int HALF = 80;

    logic          main_clock = 1'b0;
    logic          rst_n      = 1'b0;
    logic          sck        = 1'b0;
    logic          cs         = 1'b1;
    logic          si         = 1'b0;
    logic [7:0]    read_data  = 8'h00;
    logic          so;
    logic [AW-1:0] addr;
    logic          addr_valid, write_data_valid, read_data_request, read_data_captured, cmd_error;
    logic [7:0]    write_data;

    int n_checks = 0;
    int n_fail   = 0;
    int av_cnt, wr_cnt, cap_cnt, err_cnt, req_cnt;

    logic [AW-1:0] exp_av[$];
    logic [AW+7:0] exp_wr[$];
    logic [7:0]    rd_ans[$];
    logic [7:0]    rx;

    spi_memory_slave_burst dut (
        .main_clock        (main_clock),
        .rst_n             (rst_n),
        .sck               (sck),
        .cs                (cs),
        .si                (si),
        .so                (so),
        .addr              (addr),
        .addr_valid        (addr_valid),
        .write_data        (write_data),
        .write_data_valid  (write_data_valid),
        .read_data         (read_data),
        .read_data_request (read_data_request),
        .read_data_captured(read_data_captured),
        .cmd_error         (cmd_error)
    );

    always #5 main_clock = ~main_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor and read responder, sampling on the falling main_clock edge.
    always @(negedge main_clock) begin
        if (rst_n) begin
            if (addr_valid) begin
                av_cnt++;
                check("av_pending", 32'(exp_av.size() != 0), 32'd1);
                if (exp_av.size() != 0) check("av_addr", 32'(addr), 32'(exp_av.pop_front()));
            end
            if (write_data_valid) begin
                wr_cnt++;
                check("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) check("wr_addr_data", 32'({addr, write_data}),
                                              32'(exp_wr.pop_front()));
            end
            if (read_data_request) begin
                req_cnt++;
                read_data = (rd_ans.size() != 0) ? rd_ans.pop_front() : 8'h00;
            end
            if (read_data_captured) cap_cnt++;
            if (cmd_error) err_cnt++;
        end
    end

    task automatic clr_counts();
        av_cnt = 0; wr_cnt = 0; cap_cnt = 0; err_cnt = 0; req_cnt = 0;
    endtask

    // Each bit opens with the falling edge, so a byte ends with sck high.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            sck = 1'b0;
            si  = tx[7-i];
            #HALF;
            sck = 1'b1;
            r   = {r[6:0], so};
            #HALF;
        end
    endtask

    task automatic send_quiet(input string tag, input logic [7:0] b);
        logic [7:0] r;
        spi_bits(b, 8, r);
        check(tag, 32'(r), 32'h0);
    endtask

    task automatic cs_start();
        clr_counts();
        cs = 1'b0;
        #(HALF * 2);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        #(HALF * 3);
        sck = 1'b0;
        #(HALF * 2);
    endtask

    initial begin
        repeat (4) @(posedge main_clock);
        @(negedge main_clock);
        check("rst_so", 32'(so), 32'h0);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_pulses", 32'({addr_valid, write_data_valid, read_data_request,
                                 read_data_captured, cmd_error}), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(posedge main_clock);

        // Burst write
        exp_av.push_back(16'h12AB);
        exp_wr.push_back({16'h12AB, 8'h5A});
        exp_wr.push_back({16'h12AC, 8'hC3});
        cs_start();
        send_quiet("wr_so_cmd", 8'h02);
        send_quiet("wr_so_a1", 8'h12);
        send_quiet("wr_so_a0", 8'hAB);
        send_quiet("wr_so_d0", 8'h5A);
        send_quiet("wr_so_d1", 8'hC3);
        cs_end();
        check("wr_count", 32'(wr_cnt), 32'd2);
        check("wr_av_count", 32'(av_cnt), 32'd1);
        check("wr_final_addr", 32'(addr), 32'h12AD);

        // Burst read
        rd_ans.push_back(8'hAB);
        rd_ans.push_back(8'h53);
        exp_av.push_back(16'h00AB);
        exp_av.push_back(16'h00AC);
        exp_av.push_back(16'h00AD);
        cs_start();
        send_quiet("rd_so_cmd", 8'h03);
        send_quiet("rd_so_a1", 8'h00);
        send_quiet("rd_so_a0", 8'hAB);
        spi_bits(8'h00, 8, rx);
        check("rd_byte0", 32'(rx), 32'hAB);
        spi_bits(8'h00, 8, rx);
        check("rd_byte1", 32'(rx), 32'h53);
        cs_end();
        check("rd_captured", 32'(cap_cnt), 32'd2);
        check("rd_av_count", 32'(av_cnt), 32'd3);
        check("rd_req_count", 32'(req_cnt), 32'd3);

        // Fast read with dummy cycles
        rd_ans.push_back(8'h3C);
        exp_av.push_back(16'h0010);
        exp_av.push_back(16'h0011);
        cs_start();
        send_quiet("fr_so_cmd", 8'h0B);
        send_quiet("fr_so_a1", 8'h00);
        send_quiet("fr_so_a0", 8'h10);
        send_quiet("fr_so_dummy", 8'hFF);
        spi_bits(8'h00, 8, rx);
        check("fr_byte0", 32'(rx), 32'h3C);
        cs_end();
        check("fr_captured", 32'(cap_cnt), 32'd1);

        // Address wrap on write
        exp_av.push_back(16'hFFFF);
        exp_wr.push_back({16'hFFFF, 8'h11});
        exp_wr.push_back({16'h0000, 8'h22});
        cs_start();
        send_quiet("wrap_cmd", 8'h02);
        send_quiet("wrap_a1", 8'hFF);
        send_quiet("wrap_a0", 8'hFF);
        send_quiet("wrap_d0", 8'h11);
        send_quiet("wrap_d1", 8'h22);
        cs_end();
        check("wrap_count", 32'(wr_cnt), 32'd2);
        check("wrap_final_addr", 32'(addr), 32'h0001);

        // Unknown opcode, then a normal read
        cs_start();
        send_quiet("bad_cmd", 8'h9F);
        send_quiet("bad_b0", 8'h01);
        send_quiet("bad_b1", 8'h02);
        send_quiet("bad_b2", 8'h03);
        cs_end();
        check("bad_err", 32'(err_cnt), 32'd1);
        check("bad_other", 32'(av_cnt + wr_cnt + cap_cnt + req_cnt), 32'd0);
        rd_ans.push_back(8'h77);
        exp_av.push_back(16'h0040);
        exp_av.push_back(16'h0041);
        cs_start();
        send_quiet("after_cmd", 8'h03);
        send_quiet("after_a1", 8'h00);
        send_quiet("after_a0", 8'h40);
        spi_bits(8'h00, 8, rx);
        check("after_byte0", 32'(rx), 32'h77);
        cs_end();
        check("after_err", 32'(err_cnt), 32'd0);
        check("after_captured", 32'(cap_cnt), 32'd1);

        // Abort mid-byte during write
        exp_av.push_back(16'h1200);
        cs_start();
        send_quiet("abort_cmd", 8'h02);
        send_quiet("abort_a1", 8'h12);
        send_quiet("abort_a0", 8'h00);
        spi_bits(8'hA5, 5, rx);
        cs_end();
        check("abort_wr", 32'(wr_cnt), 32'd0);
        check("abort_addr", 32'(addr), 32'h1200);

        // Reset asserted mid-read
        rd_ans.push_back(8'h5E);
        exp_av.push_back(16'h0300);
        exp_av.push_back(16'h0301);
        cs_start();
        send_quiet("rst_rd_cmd", 8'h03);
        send_quiet("rst_rd_a1", 8'h03);
        send_quiet("rst_rd_a0", 8'h00);
        spi_bits(8'h00, 4, rx);
        check("rst_rd_nibble", 32'(rx), 32'h05);
        @(negedge main_clock);
        rst_n = 1'b0;
        repeat (3) @(negedge main_clock);
        check("midrst_so", 32'(so), 32'h0);
        check("midrst_addr", 32'(addr), 32'h0);
        check("midrst_pulses", 32'({addr_valid, write_data_valid, read_data_request,
                                    read_data_captured, cmd_error}), 32'h0);
        sck = 1'b0;
        cs  = 1'b1;
        repeat (4) @(posedge main_clock);
        rst_n = 1'b1;
        repeat (8) @(posedge main_clock);

        // Recovery read after reset
        rd_ans.push_back(8'h99);
        exp_av.push_back(16'h0005);
        exp_av.push_back(16'h0006);
        cs_start();
        send_quiet("rec_cmd", 8'h03);
        send_quiet("rec_a1", 8'h00);
        send_quiet("rec_a0", 8'h05);
        spi_bits(8'h00, 8, rx);
        check("rec_byte0", 32'(rx), 32'h99);
        cs_end();

        check("end_av_queue", 32'(exp_av.size()), 32'd0);
        check("end_wr_queue", 32'(exp_wr.size()), 32'd0);
        check("end_rd_queue", 32'(rd_ans.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
